// File: rtl/count_seg_driver_pkg.sv
// Shared types and constants for the two-digit hex 7-segment driver.
// This package holds the digit-state enum, the digit-enable codes and the nibble-to-segment table.
package count_seg_pkg;

    typedef enum logic {
        DIG_LO = 1'b0,
        DIG_HI = 1'b1
    } dig_state_t;

    localparam logic [1:0] DIG_SEL_BLANK = 2'b00;
    localparam logic [1:0] DIG_SEL_LO    = 2'b01;
    localparam logic [1:0] DIG_SEL_HI    = 2'b10;

    // Entry n holds the segments for hex digit n. Bit 0 is segment a and bit 6 is segment g.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/count_seg_driver_hex_to_seg7.sv
// Combinational decoder from a hex nibble to active-high 7-segment pattern (a..g).
module hex_to_seg7
    import count_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_seg_bit
            assign o_seg[gi] = HEX_SEG_TABLE[i_nibble][gi];
        end
    endgenerate

endmodule

// File: rtl/count_seg_driver.sv
// Snapshots an 8-bit count and scans it as two hex digits on a multiplexed 7-seg display.
// Optional: define LEADING_ZERO_BLANK_EN to blank the high digit when its nibble is zero.
module count_seg_driver
    import count_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int BLANK_CYC   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    input  logic       count_valid,
    input  logic       freeze,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       dp,
    output logic       snap_ack
);

    localparam int              CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    dig_state_t       r_state;
    logic [7:0]       r_snap;
    logic [7:0]       r_disp;
    logic [6:0]       r_seg;
    logic [1:0]       r_dig_sel;
    logic             r_dp;
    logic             r_snap_ack;

    dig_state_t       w_state_next;
    logic             w_wrap;
    logic             w_capture;
    logic             w_blank;
    logic             w_hi_suppress;
    logic [3:0]       w_nibble;
    logic [6:0]       w_hex_seg;
    logic [6:0]       w_seg_next;
    logic [1:0]       w_dig_sel_next;
    logic             w_dp_next;

    // An explicit compare against the terminal count lets REFRESH_DIV be a non-power-of-two value.
    assign w_wrap    = (r_cnt == CNT_MAX);
    assign w_capture = count_valid && !freeze;
    assign w_blank   = (int'(r_cnt) < BLANK_CYC);
    assign w_nibble  = (r_state == DIG_HI) ? r_disp[7:4] : r_disp[3:0];

`ifdef LEADING_ZERO_BLANK_EN
    assign w_hi_suppress = (r_disp[7:4] == 4'h0);
`else
    assign w_hi_suppress = 1'b0;
`endif

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_hex_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIG_LO;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_wrap) begin
            w_state_next = (r_state == DIG_LO) ? DIG_HI : DIG_LO;
        end
    end

    // The display copy updates only at frame boundaries. A capture on the same edge appears one frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap     <= '0;
            r_disp     <= '0;
            r_snap_ack <= 1'b0;
        end else begin
            r_snap_ack <= w_capture;
            if (w_capture) begin
                r_snap <= count;
            end
            if (w_wrap && (r_state == DIG_HI)) begin
                r_disp <= r_snap;
            end
        end
    end

    always_comb begin
        w_seg_next     = '0;
        w_dig_sel_next = DIG_SEL_BLANK;
        w_dp_next      = 1'b0;
        if (!w_blank) begin
            if (r_state == DIG_LO) begin
                w_dig_sel_next = DIG_SEL_LO;
                w_seg_next     = w_hex_seg;
                w_dp_next      = freeze;
            end else if (!w_hi_suppress) begin
                w_dig_sel_next = DIG_SEL_HI;
                w_seg_next     = w_hex_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg     <= '0;
            r_dig_sel <= DIG_SEL_BLANK;
            r_dp      <= 1'b0;
        end else begin
            r_seg     <= w_seg_next;
            r_dig_sel <= w_dig_sel_next;
            r_dp      <= w_dp_next;
        end
    end

    assign seg      = r_seg;
    assign dig_sel  = r_dig_sel;
    assign dp       = r_dp;
    assign snap_ack = r_snap_ack;

endmodule

// File: tb/tb_count_seg_driver.sv
// Self-checking bench for count_seg_driver (REFRESH_DIV=4, BLANK_CYC=1) using a cycle-level reference model and scoreboard.
module tb_count_seg_driver;

    logic       clk;
    logic       rst;
    logic [7:0] count;
    logic       count_valid;
    logic       freeze;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    logic       dp;
    logic       snap_ack;

    int n_checks = 0;
    int n_errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] dig;
        logic       dp;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];

    int         m_cnt   = 0;
    bit         m_state = 1'b0;
    logic [7:0] m_snap  = '0;
    logic [7:0] m_disp  = '0;

    count_seg_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYC   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count       (count),
        .count_valid (count_valid),
        .freeze      (freeze),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .dp          (dp),
        .snap_ack    (snap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // The reference model predicts the registered outputs for each edge from the inputs at that edge.
    always @(posedge clk) begin : model
        exp_t e;
        bit   wrap;
        e = '0;
        if (rst) begin
            m_cnt   = 0;
            m_state = 1'b0;
            m_snap  = '0;
            m_disp  = '0;
        end else begin
            e.ack = count_valid && !freeze;
            if (m_cnt >= 1) begin
                if (!m_state) begin
                    e.dig = 2'b01;
                    e.seg = hex7(m_disp[3:0]);
                    e.dp  = freeze;
                end else if (!(LZ && m_disp[7:4] == 4'h0)) begin
                    e.dig = 2'b10;
                    e.seg = hex7(m_disp[7:4]);
                end
            end
            wrap = (m_cnt == 3);
            if (wrap && m_state) m_disp = m_snap;
            if (count_valid && !freeze) m_snap = count;
            if (wrap) m_state = !m_state;
            m_cnt = wrap ? 0 : m_cnt + 1;
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_seg", 32'(seg), 32'(e.seg));
            check_eq("sb_dig_sel", 32'(dig_sel), 32'(e.dig));
            check_eq("sb_dp", 32'(dp), 32'(e.dp));
            check_eq("sb_snap_ack", 32'(snap_ack), 32'(e.ack));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // This task returns at the negedge just before a frame-boundary edge.
    task automatic wait_boundary();
        int n = 0;
        while (!(m_state && m_cnt == 3) && n < 20) begin
            tick();
            n++;
        end
        check_eq("boundary_wait_bound", 32'(n < 20), 32'd1);
    endtask

    task automatic wait_first_lit();
        int n = 0;
        while (dig_sel == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check_eq("first_lit_bound", 32'(n < 20), 32'd1);
        check_eq("first_lit_dig_sel", 32'(dig_sel), 32'h1);
        check_eq("first_lit_seg", 32'(seg), 32'h3F);
        $display("first lit digit: dig_sel=%b seg=%h", dig_sel, seg);
    endtask

    task automatic strobe(input logic [7:0] val);
        count       = val;
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
        check_eq("snap_ack", 32'(snap_ack), 32'(!freeze));
        $display("strobe count=%h freeze=%b snap_ack=%b", val, freeze, snap_ack);
    endtask

    // This task watches the eight output cycles of one frame, starting at the negedge after a boundary.
    task automatic watch_frame(input logic [6:0] lo, input logic [6:0] hi, input bit hi_blank, input bit dp_lo);
        int n_lo = 0;
        int n_hi = 0;
        repeat (8) begin
            tick();
            if (dig_sel == 2'b01) begin
                n_lo++;
                check_eq("frame_lo_seg", 32'(seg), 32'(lo));
                check_eq("frame_lo_dp", 32'(dp), 32'(dp_lo));
            end else if (dig_sel == 2'b10) begin
                n_hi++;
                check_eq("frame_hi_seg", 32'(seg), 32'(hi));
                check_eq("frame_hi_dp", 32'(dp), 32'd0);
            end
        end
        check_eq("frame_lo_cycles", 32'(n_lo), 32'd3);
        check_eq("frame_hi_cycles", 32'(n_hi), hi_blank ? 32'd0 : 32'd3);
        $display("frame: lo_cycles=%0d hi_cycles=%0d expect lo=%h hi=%h", n_lo, n_hi, lo, hi);
    endtask

    initial begin
        rst         = 1'b1;
        count       = '0;
        count_valid = 1'b0;
        freeze      = 1'b0;
        repeat (3) tick();
        check_eq("reset_seg", 32'(seg), 32'h0);
        check_eq("reset_dig_sel", 32'(dig_sel), 32'h0);
        rst = 1'b0;
        wait_first_lit();

        strobe(8'hA5);
        tick();
        check_eq("snap_ack_single", 32'(snap_ack), 32'd0);
        wait_boundary();
        tick();
        watch_frame(7'h6D, 7'h77, 1'b0, 1'b0);

        freeze = 1'b1;
        strobe(8'h3C);
        wait_boundary();
        tick();
        watch_frame(7'h6D, 7'h77, 1'b0, 1'b1);
        freeze = 1'b0;
        strobe(8'h3C);
        wait_boundary();
        tick();
        watch_frame(7'h39, 7'h4F, 1'b0, 1'b0);

        wait_boundary();
        count       = 8'h12;
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
        check_eq("race_snap_ack", 32'(snap_ack), 32'd1);
        $display("strobe count=12 on frame boundary");
        watch_frame(7'h39, 7'h4F, 1'b0, 1'b0);
        watch_frame(7'h5B, 7'h06, 1'b0, 1'b0);

        strobe(8'h07);
        wait_boundary();
        tick();
        watch_frame(7'h07, 7'h3F, LZ, 1'b0);

        strobe(8'hFF);
        wait_boundary();
        tick();
        begin
            int n = 0;
            while (!(m_state && m_cnt == 2) && n < 20) begin
                tick();
                n++;
            end
            check_eq("mid_reset_wait_bound", 32'(n < 20), 32'd1);
        end
        rst = 1'b1;
        tick();
        check_eq("mid_reset_dig_sel", 32'(dig_sel), 32'h0);
        check_eq("mid_reset_seg", 32'(seg), 32'h0);
        check_eq("mid_reset_ack", 32'(snap_ack), 32'h0);
        $display("reset asserted mid-frame");
        tick();
        rst = 1'b0;
        wait_first_lit();
        wait_boundary();
        tick();
        watch_frame(7'h3F, 7'h3F, LZ, 1'b0);

        repeat (80) begin
            count       = 8'($urandom);
            count_valid = ($urandom_range(0, 2) == 0);
            freeze      = ($urandom_range(0, 4) == 0);
            tick();
        end
        count_valid = 1'b0;
        freeze      = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
